// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared distance-datapath encodings and BCD constants
package bin2bcd_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] in_i,
    output logic [BCD_DIGIT_W-1:0] out_o
);
    assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one input bit per clock
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          ready,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);
    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CMP_W = (BIN_W + 1 > ACC_W) ? BIN_W + 1 : ACC_W;
    localparam logic [CMP_W-1:0] MAX_V = CMP_W'(10 ** DIGITS - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovf_out_q, ovf_out_d;
    logic               done_q, done_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (acc_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .out_o (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_out_q;

    // State and datapath registers; reset aborts any conversion and clears the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_sh_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_sh_q  <= bin_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    // Next state: capture on start, correct-then-shift while counting bits, publish saturated result
    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                bin_sh_d = bin_in;
                acc_d    = '0;
                cnt_d    = CNT_W'(BIN_W);
                ovf_d    = CMP_W'(bin_in) > MAX_V;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                {acc_d, bin_sh_d} = {adj, bin_sh_q} << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                bcd_d     = ovf_q ? {DIGITS{BCD_NINE}} : acc_q;
                ovf_out_d = ovf_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of the sequential binary-to-BCD converter
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        ready, done, overflow;
    logic [15:0] bcd_out;

    int errors = 0;
    int checks = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .ready    (ready),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic convert(input logic [13:0] v, output int lat, output logic busy);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start = 1'b0;
        busy  = ~ready;
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_dones(input int n, output int d);
        d = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done) d++;
        end
    endtask

    int          lat, dones, q[$], nxt, seen, last, bad_int, exp_v;
    logic        busy, held, nib_ok;
    logic [15:0] got;
    int          vals[5]  = '{1234, 9999, 10000, 16383, 5};
    logic [15:0] ebcd[5]  = '{16'h1234, 16'h9999, 16'h9999, 16'h9999, 16'h0005};
    logic        eovf[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", overflow, 0);

        convert(14'd0, lat, busy);
        check("zero_busy", busy, 1);
        check("zero_latency", lat, 15);
        check("zero_bcd", bcd_out, 16'h0000);
        check("zero_ovf", overflow, 0);
        check("zero_ready_at_done", ready, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);

        foreach (vals[i]) begin
            convert(14'(vals[i]), lat, busy);
            check($sformatf("vec%0d_latency", vals[i]), lat, 15);
            check($sformatf("vec%0d_bcd", vals[i]), bcd_out, ebcd[i]);
            check($sformatf("vec%0d_ovf", vals[i]), overflow, eovf[i]);
        end

        start  = 1'b1;
        bin_in = 14'd4321;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 14'd9876;
        dones  = 0;
        held   = 1'b1;
        got    = '0;
        for (int c = 1; c <= 30; c++) begin
            start = (c == 3 || c == 7);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dones++;
                got = bcd_out;
            end else if (dones == 0 && bcd_out !== 16'h0005) held = 1'b0;
        end
        check("ignore_dones", dones, 1);
        check("ignore_result", got, 16'h4321);
        check("ignore_held", held, 1);

        start  = 1'b1;
        bin_in = 14'd0;
        q.push_back(0);
        nxt     = 1;
        seen    = 0;
        last    = -1;
        bad_int = 0;
        nib_ok  = 1'b1;
        for (int cyc = 0; cyc < 20000 && seen < 1000; cyc++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 4; n++)
                if (bcd_out[4*n +: 4] > 4'd9) nib_ok = 1'b0;
            if (done) begin
                exp_v = (q.size() > 0) ? q.pop_front() : -1;
                check($sformatf("sweep_%0d", exp_v), bcd_out, ref_bcd(exp_v));
                if (last >= 0 && cyc - last != 16) bad_int++;
                last = cyc;
                seen++;
            end
            if (ready) begin
                if (nxt <= 999) begin
                    bin_in = 14'(nxt);
                    q.push_back(nxt);
                    nxt++;
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        check("sweep_count", seen, 1000);
        check("sweep_interval", bad_int, 0);
        check("sweep_nibbles", nib_ok, 1);
        check("sweep_last_ovf", overflow, 0);

        start  = 1'b1;
        bin_in = 14'd777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_bcd", bcd_out, 0);
        check("abort_ovf", overflow, 0);
        check("abort_done", done, 0);
        count_dones(20, dones);
        check("abort_no_done", dones, 0);
        convert(14'd4095, lat, busy);
        check("fresh_latency", lat, 15);
        check("fresh_bcd", bcd_out, 16'h4095);

        rst    = 1'b1;
        start  = 1'b1;
        bin_in = 14'd42;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_ready", ready, 1);
        check("rst_start_bcd", bcd_out, 0);
        count_dones(20, dones);
        check("rst_start_no_done", dones, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
